// File: rtl/waveform_measure.sv
// Recovers period, peak and trough of an 8-bit unsigned waveform centred on MID,
// using Schmitt-trigger rising-crossing detection and a per-period sample counter.
module waveform_measure #(
    parameter int MID   = 128,
    parameter int HYST  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [7:0]       sample,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       peak,
    output logic [7:0]       trough,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [7:0] UPPER = 8'(MID + HYST);
    localparam logic [7:0] LOWER = 8'(MID - HYST);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t           state_q, state_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       run_max_q, run_max_d;
    logic [7:0]       run_min_q, run_min_d;
    logic [CNT_W:0]   prev_period_q, prev_period_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       peak_q, peak_d;
    logic [7:0]       trough_q, trough_d;
    logic             meas_valid_q, meas_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             rising;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W:0]   diff;

    always_comb begin
        state_d       = state_q;
        primed_d      = primed_q;
        cnt_d         = cnt_q;
        run_max_d     = run_max_q;
        run_min_d     = run_min_q;
        prev_period_d = prev_period_q;
        period_d      = period_q;
        peak_d        = peak_q;
        trough_d      = trough_q;
        meas_valid_d  = 1'b0;
        locked_d      = locked_q;
        timeout_d     = 1'b0;

        cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        diff    = (cnt_inc >= prev_period_q) ? (cnt_inc - prev_period_q)
                                             : (prev_period_q - cnt_inc);
        rising  = sample_valid && (state_q == LOW) && (sample >= UPPER);

        if (sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (sample <= LOWER)      state_d = LOW;
                    else if (sample >= UPPER) state_d = HIGH;
                end
                HIGH: if (sample <= LOWER) state_d = LOW;
                LOW:  if (sample >= UPPER) state_d = HIGH;
                default: state_d = IDLE;
            endcase

            if (rising) begin
                if (primed_q) begin
                    // A full-range count cannot fit the output; report it pinned at max.
                    period_d      = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];
                    peak_d        = run_max_q;
                    trough_d      = run_min_q;
                    meas_valid_d  = 1'b1;
                    locked_d      = (diff <= {{CNT_W{1'b0}}, 1'b1});
                    prev_period_d = cnt_inc;
                end
                cnt_d     = '0;
                run_max_d = sample;
                run_min_d = sample;
                primed_d  = 1'b1;
            end else if (primed_q) begin
                if (cnt_q == {CNT_W{1'b1}}) begin
                    // Lost the signal: start over as if freshly reset, keeping old results.
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                    primed_d  = 1'b0;
                    locked_d  = 1'b0;
                    cnt_d     = '0;
                    run_max_d = 8'h00;
                    run_min_d = 8'hFF;
                end else begin
                    cnt_d     = cnt_inc[CNT_W-1:0];
                    run_max_d = (sample > run_max_q) ? sample : run_max_q;
                    run_min_d = (sample < run_min_q) ? sample : run_min_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            primed_q      <= 1'b0;
            cnt_q         <= '0;
            run_max_q     <= 8'h00;
            run_min_q     <= 8'hFF;
            prev_period_q <= '0;
            period_q      <= '0;
            peak_q        <= 8'h00;
            trough_q      <= 8'hFF;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            primed_q      <= primed_d;
            cnt_q         <= cnt_d;
            run_max_q     <= run_max_d;
            run_min_q     <= run_min_d;
            prev_period_q <= prev_period_d;
            period_q      <= period_d;
            peak_q        <= peak_d;
            trough_q      <= trough_d;
            meas_valid_q  <= meas_valid_d;
            locked_q      <= locked_d;
            timeout_q     <= timeout_d;
        end
    end

    assign period     = period_q;
    assign peak       = peak_q;
    assign trough     = trough_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_waveform_measure.sv
// Directed bench for waveform_measure: a triangle-wave phase accumulator stands in
// for the DDS generator; a 16-bit and an 8-bit counter instance share the stimulus.
module tb_waveform_measure;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample = 8'h00;

    logic [15:0] period;
    logic [7:0]  peak, trough;
    logic        meas_valid, locked, timeout;

    logic [7:0]  period8, peak8, trough8;
    logic        meas_valid8, locked8, timeout8;

    waveform_measure #(.MID(128), .HYST(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period(period), .peak(peak), .trough(trough),
        .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
    );

    waveform_measure #(.MID(128), .HYST(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample(sample),
        .period(period8), .peak(peak8), .trough(trough8),
        .meas_valid(meas_valid8), .locked(locked8), .timeout(timeout8)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p; int pk; int tr; int lk; int clk_no; int idx;
    } ev_t;

    typedef struct {
        int freq; bit toggle; int nsamp;
        int exp_meas; int first_idx; int per_lo; int per_hi;
        bit chk_amp; int exp_lock; int spacing;
    } vec_t;

    ev_t  evq[$];
    vec_t vecs[4];
    int   tests = 0, fails = 0;
    int   cyc = 0, vidx = 0, stray = 0, to8_cnt = 0, m8_cnt = 0;
    logic [7:0]  phase = 8'h00;
    logic [15:0] last_p;
    logic [7:0]  last_pk, last_tr;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst) begin
            if (meas_valid)
                evq.push_back('{int'(period), int'(peak), int'(trough), int'(locked), cyc, vidx - 1});
            else if (period != last_p || peak != last_pk || trough != last_tr)
                stray++;
            if (timeout8)    to8_cnt++;
            if (meas_valid8) m8_cnt++;
        end
        last_p  = period;
        last_pk = peak;
        last_tr = trough;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] tri_wave(input logic [7:0] ph);
        if (ph < 8'd128) return {ph[6:0], 1'b0};
        return 8'd255 - {ph[6:0], 1'b0};
    endfunction

    task automatic step(input logic v, input logic [7:0] s);
        sample_valid = v;
        sample = s;
        @(posedge clk);
        if (v) vidx++;
        #1;
    endtask

    task automatic run(input int freq, input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            step(1'b1, tri_wave(phase));
            phase = phase + 8'(freq);
            if (toggle) step(1'b0, 8'h55);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        phase = 8'h00;
        vidx = 0;
        stray = 0;
        to8_cnt = 0;
        m8_cnt = 0;
        evq.delete();
    endtask

    initial begin
        int n0, first_to, m8_before, last;

        vecs[0] = '{1, 1'b0, 900,  3, 324, 256, 256, 1'b1, 1, 256};
        vecs[1] = '{4, 1'b0, 700, 10,  81,  64,  64, 1'b1, 1,  64};
        vecs[2] = '{3, 1'b0, 1000, 11, 108,  85,  86, 1'b0, 1,   0};
        vecs[3] = '{1, 1'b1, 900,  3, 324, 256, 256, 1'b1, 1, 512};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_period", period, 0);
        chk("reset_peak", peak, 0);
        chk("reset_trough", trough, 255);
        chk("reset_meas_valid", meas_valid, 0);
        chk("reset_locked", locked, 0);
        chk("reset_timeout", timeout, 0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            run(vecs[v].freq, vecs[v].nsamp, vecs[v].toggle);
            $display("[TB] vec %0d freq=%0d toggle=%0d meas=%0d", v, vecs[v].freq, vecs[v].toggle, evq.size());
            chk($sformatf("v%0d_meas_count", v), evq.size(), vecs[v].exp_meas);
            chk($sformatf("v%0d_stray_updates", v), stray, 0);
            if (evq.size() >= 2) begin
                last = evq.size() - 1;
                chk($sformatf("v%0d_first_idx", v), evq[0].idx, vecs[v].first_idx);
                chk($sformatf("v%0d_first_unlocked", v), evq[0].lk, 0);
                chk($sformatf("v%0d_period_in_range", v),
                    (evq[last].p >= vecs[v].per_lo && evq[last].p <= vecs[v].per_hi) ? 1 : 0, 1);
                chk($sformatf("v%0d_locked", v), evq[last].lk, vecs[v].exp_lock);
                chk($sformatf("v%0d_locked_out", v), locked, vecs[v].exp_lock);
                if (vecs[v].chk_amp) begin
                    chk($sformatf("v%0d_peak", v), evq[last].pk, 255);
                    chk($sformatf("v%0d_trough", v), evq[last].tr, 0);
                end
                if (vecs[v].spacing != 0)
                    chk($sformatf("v%0d_spacing", v), evq[last].clk_no - evq[last-1].clk_no, vecs[v].spacing);
            end
        end

        // Frequency step 4 -> 8: straddling period 39 unlocks, then settles at 32.
        do_reset();
        run(4, 350, 1'b0);
        n0 = evq.size();
        chk("sw_meas_before", n0, 5);
        run(8, 200, 1'b0);
        $display("[TB] switch 4->8 meas_after=%0d", evq.size() - n0);
        chk("sw_meas_after", evq.size() - n0, 6);
        if (evq.size() > n0) begin
            chk("sw_straddle_period", evq[n0].p, 39);
            chk("sw_straddle_unlocked", evq[n0].lk, 0);
            chk("sw_final_period", evq[evq.size()-1].p, 32);
            chk("sw_final_locked", evq[evq.size()-1].lk, 1);
        end

        // Saturation on the 8-bit counter instance after a steady period of 128.
        do_reset();
        run(2, 330, 1'b0);
        chk("to_locked_before", locked8, 1);
        chk("to_period_before", period8, 128);
        first_to = -1;
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 8'd130);
            if (timeout8 && first_to < 0) first_to = k;
        end
        $display("[TB] timeout at constant sample %0d", first_to);
        chk("to_first_index", first_to, 216);
        chk("to_pulse_count", to8_cnt, 1);
        chk("to_locked_after", locked8, 0);
        chk("to_period_held", period8, 128);
        chk("to_peak_held", peak8, 255);
        chk("to_trough_held", trough8, 0);
        phase = 8'h00;
        m8_before = m8_cnt;
        run(2, 200, 1'b0);
        chk("to_remeasure_count", m8_cnt - m8_before, 1);

        // In-band noise never leaves IDLE.
        do_reset();
        for (int k = 0; k < 300; k++) step(1'b1, 8'(125 + (k * 3) % 7));
        $display("[TB] noise meas=%0d", evq.size());
        chk("noise_meas_count", evq.size(), 0);
        chk("noise_period", period, 0);
        chk("noise_trough", trough, 255);

        // Asynchronous reset mid-period.
        do_reset();
        run(1, 500, 1'b0);
        chk("rst_meas_before", evq.size(), 1);
        chk("rst_period_before", period, 256);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_period", period, 0);
        chk("rst_async_peak", peak, 0);
        chk("rst_async_trough", trough, 255);
        chk("rst_async_locked", locked, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        evq.delete();
        vidx = 0;
        run(1, 500, 1'b0);
        $display("[TB] post-reset meas=%0d", evq.size());
        chk("rst_meas_after", evq.size(), 1);
        if (evq.size() >= 1) begin
            chk("rst_first_idx", evq[0].idx, 336);
            chk("rst_first_period", evq[0].p, 256);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
